// File: rtl/cs_pkg.sv
// Shared constants, state encoding and output arithmetic for the sequenced CS datapath.
package cs_pkg;
    localparam int N_TAPS  = 9;
    localparam int SUM_W   = 12;
    localparam int DIV_CYC = 12;

    typedef enum logic [2:0] {FILL, ACCEPT, SUM, DIV, SCAN, CALC, OUT} state_t;

    // Y = floor((sum + 9*appr) / 8); the 13-bit intermediate peaks at 4590.
    function automatic logic [9:0] calc_y(input logic [SUM_W-1:0] sum, input logic [7:0] appr);
        logic [12:0] t;
        t = {1'b0, sum} + {2'b0, appr, 3'b0} + {5'b0, appr};
        return t[12:3];
    endfunction
endpackage

// File: rtl/cs_div9.sv
// Restoring divide-by-9, one quotient bit per cycle; the start edge performs the first step.
module cs_div9
    import cs_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    output logic [7:0]       quot,
    output logic             done
);

    logic             run;
    logic [3:0]       cnt;
    logic [3:0]       rem;
    logic [SUM_W-1:0] qd;
    logic [SUM_W-1:0] src;
    logic [4:0]       trial;
    logic             fits;

    // Dividend bits shift out of the top of qd while quotient bits shift in at the bottom.
    always_comb begin
        src   = start ? dividend : qd;
        trial = {start ? 4'd0 : rem, src[SUM_W-1]};
        fits  = (trial >= 5'd9);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run  <= 1'b0;
            cnt  <= 4'd0;
            rem  <= 4'd0;
            qd   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || run) begin
                rem <= fits ? 4'(trial - 5'd9) : trial[3:0];
                qd  <= {src[SUM_W-2:0], fits};
                if (start) begin
                    run <= 1'b1;
                    cnt <= 4'd1;
                end else if (cnt == 4'(DIV_CYC - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    assign quot = qd[7:0];

endmodule

// File: rtl/cs_seq_ctrl.sv
// Handshaked 9-tap sliding-window controller: sums, averages, picks the closest entry
// at or below the average and emits Y, sharing one accumulator, divider and comparator.
module cs_seq_ctrl
    import cs_pkg::*;
#(
    parameter int DW = 8,
    parameter int YW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [DW-1:0] x_data,
    output logic          x_ready,
    output logic          y_valid,
    output logic [YW-1:0] y_data,
    input  logic          y_ready,
    output logic          busy
);

    localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);

    logic [DW-1:0]    window [N_TAPS];
    state_t           state;
    logic [3:0]       fill;
    logic [3:0]       wptr;
    logic [3:0]       wptr_next;
    logic [3:0]       idx;
    logic [SUM_W-1:0] acc;
    logic [DW-1:0]    appr;
    logic [7:0]       avg;
    logic             div_start;
    logic             div_done;
    logic             x_take;

    assign x_take    = x_valid && x_ready;
    assign wptr_next = (wptr == LAST_TAP) ? 4'd0 : wptr + 4'd1;

    always_ff @(posedge clk) begin
        if (x_take && !reset)
            window[wptr] <= x_data;
    end

    cs_div9 u_div9 (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (acc),
        .quot     (avg),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill      <= 4'd0;
            wptr      <= 4'd0;
            idx       <= 4'd0;
            acc       <= '0;
            appr      <= '0;
            div_start <= 1'b0;
            x_ready   <= 1'b0;
            y_valid   <= 1'b0;
            y_data    <= '0;
            busy      <= 1'b0;
        end else begin
            div_start <= 1'b0;
            unique case (state)
                FILL: begin
                    x_ready <= 1'b1;
                    if (x_take) begin
                        wptr <= wptr_next;
                        fill <= fill + 4'd1;
                        if (fill == LAST_TAP) begin
                            x_ready <= 1'b0;
                            busy    <= 1'b1;
                            acc     <= '0;
                            idx     <= 4'd0;
                            state   <= SUM;
                        end
                    end
                end
                ACCEPT: begin
                    x_ready <= 1'b1;
                    if (x_take) begin
                        wptr    <= wptr_next;
                        x_ready <= 1'b0;
                        busy    <= 1'b1;
                        acc     <= '0;
                        idx     <= 4'd0;
                        state   <= SUM;
                    end
                end
                SUM: begin
                    acc <= acc + SUM_W'(window[idx]);
                    if (idx == LAST_TAP) begin
                        idx       <= 4'd0;
                        div_start <= 1'b1;
                        state     <= DIV;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        appr  <= '0;
                        idx   <= 4'd0;
                        state <= SCAN;
                    end
                end
                // The minimum never exceeds the average, so some entry always qualifies.
                SCAN: begin
                    if (window[idx] <= avg && window[idx] > appr)
                        appr <= window[idx];
                    if (idx == LAST_TAP) begin
                        idx   <= 4'd0;
                        state <= CALC;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                CALC: begin
                    y_data  <= calc_y(acc, appr);
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        x_ready <= 1'b1;
                        state   <= ACCEPT;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
